// File: rtl/cache_pkg.sv
// Shared constants, FSM state type and address-field helpers for the data cache.
package cache_pkg;

  localparam int INDEX_W      = 6;
  localparam int TAG_W        = 10;
  localparam int BLOCK_W      = 64;
  localparam int WORD_W       = 32;
  localparam int WORD_SEL_BIT = 2;
  localparam int INDEX_LSB    = 3;
  localparam int TAG_LSB      = INDEX_LSB + INDEX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR      = 2'd2
  } state_t;

  // Set index, address bits [8:3].
  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[TAG_LSB-1:INDEX_LSB];
  endfunction

  // Tag, address bits [18:9].
  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[TAG_LSB+TAG_W-1:TAG_LSB];
  endfunction

  // Word select inside the 64-bit block: 0 = low word, 1 = high word.
  function automatic logic addr_word_sel(input logic [31:0] addr);
    return addr[WORD_SEL_BIT];
  endfunction

  // Pick one 32-bit word out of a block.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic              sel);
    logic [WORD_W-1:0] w;
    if (sel) begin
      w = blk[BLOCK_W-1:WORD_W];
    end else begin
      w = blk[WORD_W-1:0];
    end
    return w;
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Bus bundles around the cache: pipeline (MEM stage) side and SRAM controller side.

// Pipeline side: master is the MEM stage, slave is the cache.
interface cache_mem_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output mem_r_en, mem_w_en, address, wdata,
                  input  rdata, ready);
  modport slave  (input  mem_r_en, mem_w_en, address, wdata,
                  output rdata, ready);
endinterface

// SRAM side: master is the cache, slave is the SRAM controller.
interface cache_sram_if;
  logic        sram_read;
  logic        sram_write;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_ready;

  modport master (output sram_read, sram_write, sram_address, sram_wdata,
                  input  sram_rdata, sram_ready);
  modport slave  (input  sram_read, sram_write, sram_address, sram_wdata,
                  output sram_rdata, sram_ready);
endinterface

// File: rtl/cache_way_array.sv
// Storage for one cache way: valid/tag/data per set, asynchronous read,
// synchronous block fill and 32-bit word write. Reset clears only valid bits;
// tag and data are don't-care while invalid.
module cache_way_array #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(SETS)-1:0]  index,
  output logic                     rd_valid,
  output logic [TAG_W-1:0]         rd_tag,
  output logic [63:0]              rd_data,
  input  logic                     fill_en,
  input  logic [TAG_W-1:0]         fill_tag,
  input  logic [63:0]              fill_data,
  input  logic                     wr_en,
  input  logic                     wr_word_sel,
  input  logic [31:0]              wr_data
);

  logic [SETS-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [TAG_W-1:0] tag_d  [SETS];
  logic [63:0]      data_q [SETS];
  logic [63:0]      data_d [SETS];

  // Next-state of the arrays: a fill replaces the whole entry, a word write
  // patches one half of the block; fill wins if both are requested.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[index] = 1'b1;
      tag_d[index]   = fill_tag;
      data_d[index]  = fill_data;
    end else if (wr_en) begin
      if (wr_word_sel) begin
        data_d[index][63:32] = wr_data;
      end else begin
        data_d[index][31:0]  = wr_data;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits: cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data storage: no reset, guarded by the valid bit.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache between
// the MEM stage and the SRAM controller. Read hits complete in the same cycle;
// read misses fetch a 64-bit block; all writes go through to SRAM.
module cache_controller #(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  cache_mem_if.slave    mem,
  cache_sram_if.master  sram
);
  import cache_pkg::*;

  localparam int IDX_W = $clog2(SETS);

  state_t           state_q, state_d;
  logic [SETS-1:0]  lru_q, lru_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] req_tag;
  logic             word_sel;
  logic             wr_req;
  logic             rd_req;

  logic             valid0, valid1;
  logic [TAG_W-1:0] tag0, tag1;
  logic [63:0]      data0, data1;
  logic             hit0, hit1, hit;
  logic             victim;
  logic             fill0, fill1;
  logic             wr0, wr1;
  logic             fill_now;
  logic             wr_now;

  assign idx      = IDX_W'(addr_index(mem.address));
  assign req_tag  = TAG_W'(addr_tag(mem.address));
  assign word_sel = addr_word_sel(mem.address);

  // A write wins over a simultaneous read.
  assign wr_req = mem.mem_w_en;
  assign rd_req = mem.mem_r_en & ~mem.mem_w_en;

  assign hit0 = valid0 & (tag0 == req_tag);
  assign hit1 = valid1 & (tag1 == req_tag);
  assign hit  = hit0 | hit1;

  // Victim choice: invalid way 0 first, then invalid way 1, else the LRU way.
  always_comb begin
    if (!valid0) begin
      victim = 1'b0;
    end else if (!valid1) begin
      victim = 1'b1;
    end else begin
      victim = lru_q[idx];
    end
  end

  assign fill_now = (state_q == RD_MISS) & sram.sram_ready;
  assign wr_now   = (state_q == WR) & sram.sram_ready;
  assign fill0    = fill_now & ~victim;
  assign fill1    = fill_now &  victim;
  assign wr0      = wr_now & hit0;
  assign wr1      = wr_now & hit1 & ~hit0;

  cache_way_array #(.SETS(SETS), .TAG_W(TAG_W)) u_way0 (
    .clk         (clk),
    .rst         (rst),
    .index       (idx),
    .rd_valid    (valid0),
    .rd_tag      (tag0),
    .rd_data     (data0),
    .fill_en     (fill0),
    .fill_tag    (req_tag),
    .fill_data   (sram.sram_rdata),
    .wr_en       (wr0),
    .wr_word_sel (word_sel),
    .wr_data     (mem.wdata)
  );

  cache_way_array #(.SETS(SETS), .TAG_W(TAG_W)) u_way1 (
    .clk         (clk),
    .rst         (rst),
    .index       (idx),
    .rd_valid    (valid1),
    .rd_tag      (tag1),
    .rd_data     (data1),
    .fill_en     (fill1),
    .fill_tag    (req_tag),
    .fill_data   (sram.sram_rdata),
    .wr_en       (wr1),
    .wr_word_sel (word_sel),
    .wr_data     (mem.wdata)
  );

  // State and LRU registers; reset drops any in-flight SRAM request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      lru_q   <= lru_d;
    end
  end

  // Next-state logic: leave a busy state only in the sram_ready cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          state_d = WR;
        end else if (rd_req && !hit) begin
          state_d = RD_MISS;
        end else begin
          state_d = IDLE;
        end
      end
      RD_MISS, WR: begin
        if (sram.sram_ready) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // LRU update: after a hit or fill, point the victim at the other way.
  always_comb begin
    lru_d = lru_q;
    if ((state_q == IDLE) && rd_req && hit) begin
      lru_d[idx] = hit0;
    end else if (fill_now) begin
      lru_d[idx] = ~victim;
    end else if (wr_now && hit) begin
      lru_d[idx] = hit0;
    end else begin
      lru_d = lru_q;
    end
  end

  // Outputs: SRAM strobes come from state only; ready/rdata follow the
  // hit path in IDLE and bypass the SRAM block in the fill cycle.
  always_comb begin
    sram.sram_read  = 1'b0;
    sram.sram_write = 1'b0;
    mem.ready       = 1'b1;
    mem.rdata       = 32'h0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          mem.ready = 1'b0;
        end else if (rd_req) begin
          if (hit) begin
            mem.ready = 1'b1;
            mem.rdata = block_word(hit0 ? data0 : data1, word_sel);
          end else begin
            mem.ready = 1'b0;
          end
        end else begin
          mem.ready = 1'b1;
        end
      end
      RD_MISS: begin
        sram.sram_read = 1'b1;
        mem.ready      = sram.sram_ready;
        if (sram.sram_ready) begin
          mem.rdata = block_word(sram.sram_rdata, word_sel);
        end else begin
          mem.rdata = 32'h0;
        end
      end
      WR: begin
        sram.sram_write = 1'b1;
        mem.ready       = sram.sram_ready;
      end
      default: begin
        mem.ready = 1'b1;
      end
    endcase
  end

  assign sram.sram_address = mem.address;
  assign sram.sram_wdata   = mem.wdata;

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: the bench plays both the MEM stage and
// the SRAM controller, with hand-computed expected words.
module tb_cache_controller;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cache_mem_if  mem_bus ();
  cache_sram_if sram_bus ();

  cache_controller #(.SETS(64), .TAG_W(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .mem  (mem_bus),
    .sram (sram_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access; the bench answers as the SRAM controller after lat busy cycles.
  task automatic xfer(input logic wr, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wd, input logic miss, input int lat,
                      input logic [63:0] blk, input logic [31:0] exp_rd);
    @(negedge clk);
    mem_bus.mem_w_en    = wr;
    mem_bus.mem_r_en    = rd;
    mem_bus.address     = addr;
    mem_bus.wdata       = wd;
    sram_bus.sram_rdata = blk;
    #1;
    if (!miss && !wr) begin
      chk("hit_ready", mem_bus.ready, 1'b1);
      chk("hit_rdata", mem_bus.rdata, exp_rd);
      chk("hit_no_sram", {sram_bus.sram_read, sram_bus.sram_write}, 2'b00);
      @(negedge clk);
      mem_bus.mem_r_en = 1'b0;
      mem_bus.mem_w_en = 1'b0;
    end else begin
      chk("req_stall", mem_bus.ready, 1'b0);
      chk("req_idle_strobes", {sram_bus.sram_read, sram_bus.sram_write}, 2'b00);
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        #1;
        chk("busy_ready", mem_bus.ready, 1'b0);
        chk("busy_strobes", {sram_bus.sram_read, sram_bus.sram_write}, {~wr, wr});
      end
      sram_bus.sram_ready = 1'b1;
      #1;
      chk("done_ready", mem_bus.ready, 1'b1);
      chk("done_addr", sram_bus.sram_address, addr);
      if (wr) begin
        chk("done_wdata", sram_bus.sram_wdata, wd);
      end else begin
        chk("done_rdata", mem_bus.rdata, exp_rd);
      end
      @(negedge clk);
      sram_bus.sram_ready = 1'b0;
      mem_bus.mem_r_en    = 1'b0;
      mem_bus.mem_w_en    = 1'b0;
      #1;
      chk("after_strobes", {sram_bus.sram_read, sram_bus.sram_write}, 2'b00);
      chk("after_ready", mem_bus.ready, 1'b1);
      chk("after_rdata", mem_bus.rdata, 32'h0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    mem_bus.mem_r_en    = 1'b0;
    mem_bus.mem_w_en    = 1'b0;
    mem_bus.address     = 32'h0;
    mem_bus.wdata       = 32'h0;
    sram_bus.sram_rdata = 64'h0;
    sram_bus.sram_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", mem_bus.ready, 1'b1);
    chk("rst_rdata", mem_bus.rdata, 32'h0);
    chk("rst_strobes", {sram_bus.sram_read, sram_bus.sram_write}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // Cold read, then hit on the other word of the same block.
    xfer(1'b0, 1'b1, 32'h0000_0404, 32'h0, 1'b1, 5, 64'hAAAA_BBBB_1111_2222, 32'hAAAA_BBBB);
    xfer(1'b0, 1'b1, 32'h0000_0400, 32'h0, 1'b0, 0, 64'h0, 32'h1111_2222);

    // Eviction: 0x804 fills way 1, 0x404 makes way 1 LRU, 0xC04 replaces way 1.
    xfer(1'b0, 1'b1, 32'h0000_0804, 32'h0, 1'b1, 3, 64'h5555_6666_7777_8888, 32'h5555_6666);
    xfer(1'b0, 1'b1, 32'h0000_0404, 32'h0, 1'b0, 0, 64'h0, 32'hAAAA_BBBB);
    xfer(1'b0, 1'b1, 32'h0000_0C04, 32'h0, 1'b1, 2, 64'h9999_AAAA_BBBB_CCCC, 32'h9999_AAAA);
    xfer(1'b0, 1'b1, 32'h0000_0C00, 32'h0, 1'b0, 0, 64'h0, 32'hBBBB_CCCC);
    xfer(1'b0, 1'b1, 32'h0000_0404, 32'h0, 1'b0, 0, 64'h0, 32'hAAAA_BBBB);
    xfer(1'b0, 1'b1, 32'h0000_0804, 32'h0, 1'b1, 1, 64'h1234_5678_9ABC_DEF0, 32'h1234_5678);
    xfer(1'b0, 1'b1, 32'h0000_0400, 32'h0, 1'b0, 0, 64'h0, 32'h1111_2222);

    // Write hit updates the low word only.
    xfer(1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 1'b1, 3, 64'h0, 32'h0);
    xfer(1'b0, 1'b1, 32'h0000_0400, 32'h0, 1'b0, 0, 64'h0, 32'hDEAD_BEEF);
    xfer(1'b0, 1'b1, 32'h0000_0404, 32'h0, 1'b0, 0, 64'h0, 32'hAAAA_BBBB);

    // Write miss allocates nothing: the following read still misses.
    xfer(1'b1, 1'b0, 32'h0000_1004, 32'h0BAD_F00D, 1'b1, 2, 64'h0, 32'h0);
    xfer(1'b0, 1'b1, 32'h0000_1004, 32'h0, 1'b1, 2, 64'hCAFE_BABE_0000_0001, 32'hCAFE_BABE);

    // Read and write together behave as a write.
    xfer(1'b1, 1'b1, 32'h0000_0400, 32'h0102_0304, 1'b1, 1, 64'h0, 32'h0);
    xfer(1'b0, 1'b1, 32'h0000_0400, 32'h0, 1'b0, 0, 64'h0, 32'h0102_0304);

    // Reset in the second RD_MISS cycle.
    @(negedge clk);
    mem_bus.mem_r_en = 1'b1;
    mem_bus.address  = 32'h0000_2000;
    @(negedge clk);
    #1;
    chk("rm_busy", sram_bus.sram_read, 1'b1);
    @(negedge clk);
    mem_bus.mem_r_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("rm_sram_read", sram_bus.sram_read, 1'b0);
    chk("rm_ready", mem_bus.ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    xfer(1'b0, 1'b1, 32'h0000_0400, 32'h0, 1'b1, 2, 64'h1122_3344_5566_7788, 32'h5566_7788);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
